// File: rtl/cod5_fifo_write_packer_if.sv
// cod5_fifo_write_packer_if: byte-stream input, flush control and FIFO write-side bundle
interface cod5_fifo_write_packer_if #(
  parameter int BYTE_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid_i;
  logic [BYTE_WIDTH-1:0] in_data_i;
  logic                  in_ready_o;
  logic                  flush_i;
  logic                  flush_done_o;
  logic                  fifo_full_i;
  logic                  fifo_inc_o;
  logic [DATA_WIDTH-1:0] fifo_data_o;
  logic                  busy_o;
  logic [15:0]           word_count_o;
  modport master (
    output in_valid_i, in_data_i, flush_i, fifo_full_i,
    input  in_ready_o, flush_done_o, fifo_inc_o, fifo_data_o, busy_o, word_count_o
  );
  modport slave (
    input  in_valid_i, in_data_i, flush_i, fifo_full_i,
    output in_ready_o, flush_done_o, fifo_inc_o, fifo_data_o, busy_o, word_count_o
  );
endinterface

// File: rtl/cod5_fifo_write_packer.sv
// cod5_fifo_write_packer: packs bytes little-endian into FIFO words, with padded flush
module cod5_fifo_write_packer #(
  parameter int                    BYTE_WIDTH     = 8,
  parameter int                    BYTES_PER_WORD = 2,
  parameter int                    DATA_WIDTH     = 16,
  parameter logic [BYTE_WIDTH-1:0] PAD_BYTE       = '0
) (
  input logic                  write_clk_i,
  input logic                  write_rst_ni,
  cod5_fifo_write_packer_if.slave bus
);
  localparam int IW = $clog2(BYTES_PER_WORD);
  localparam logic [IW-1:0] LAST = IW'(BYTES_PER_WORD - 1);
  typedef enum logic {FILL, FLUSH} state_t;
  state_t                r_state, w_state_n;
  logic [IW-1:0]         r_idx;
  logic [DATA_WIDTH-1:0] r_asm, r_hold, w_word, w_pad;
  logic                  r_hold_v, r_done, w_done_n;
  logic [15:0]           r_cnt;
  logic                  w_last, w_push, w_free, w_acc, w_cpl, w_load, w_idle;
  assign w_last = r_idx == LAST;
  assign w_push = r_hold_v & ~bus.fifo_full_i;
  assign w_free = ~r_hold_v | w_push;
  assign bus.in_ready_o = (r_state == FILL) & (~w_last | w_free);
  assign w_acc  = bus.in_valid_i & bus.in_ready_o;
  assign w_cpl  = w_acc & w_last;
  assign w_load = (r_state == FLUSH) & w_free;
  // idle means nothing partial remains once this cycle's byte is taken
  assign w_idle = ((r_idx == '0) & ~w_acc) | w_cpl;
  for (genvar i = 0; i < BYTES_PER_WORD; i++) begin : g_lane
    assign w_word[i*BYTE_WIDTH +: BYTE_WIDTH] = (r_idx == IW'(i)) ? bus.in_data_i
                                                : r_asm[i*BYTE_WIDTH +: BYTE_WIDTH];
    assign w_pad[i*BYTE_WIDTH +: BYTE_WIDTH]  = (IW'(i) < r_idx) ? r_asm[i*BYTE_WIDTH +: BYTE_WIDTH]
                                                : PAD_BYTE;
  end
  always_comb begin
    w_state_n = r_state;
    w_done_n  = 1'b0;
    w_state_n = (r_state == FILL) ? ((bus.flush_i & ~w_idle) ? FLUSH : FILL)
                                  : (w_free ? FILL : FLUSH);
    w_done_n  = ((r_state == FILL) & bus.flush_i & w_idle) | w_load;
  end
  always_ff @(posedge write_clk_i or negedge write_rst_ni)
    if (!write_rst_ni) r_state <= FILL;
    else               r_state <= w_state_n;
  always_ff @(posedge write_clk_i or negedge write_rst_ni) begin
    if (!write_rst_ni) begin
      r_idx    <= '0;
      r_asm    <= '0;
      r_hold   <= '0;
      r_hold_v <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_done <= w_done_n;
      if (w_acc) r_asm[r_idx*BYTE_WIDTH +: BYTE_WIDTH] <= bus.in_data_i;
      if (w_cpl | w_load) r_idx <= '0;
      else if (w_acc)     r_idx <= r_idx + 1'b1;
      if (w_cpl)       r_hold <= w_word;
      else if (w_load) r_hold <= w_pad;
      r_hold_v <= w_cpl | w_load | (r_hold_v & ~w_push);
      if (w_push) r_cnt <= r_cnt + 16'd1;
    end
  end
  assign bus.fifo_inc_o   = w_push;
  assign bus.fifo_data_o  = r_hold;
  assign bus.flush_done_o = r_done;
  assign bus.busy_o       = r_hold_v | (r_idx != '0) | (r_state == FLUSH);
  assign bus.word_count_o = r_cnt;
endmodule

// File: tb/tb_cod5_fifo_write_packer.sv
// tb_cod5_fifo_write_packer: directed and random stimulus against a queue-based packer model
module tb_cod5_fifo_write_packer;
  localparam int BW = 8, BPW = 2, DW = 16;
  localparam logic [BW-1:0] PAD = 8'h00;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  cod5_fifo_write_packer_if #(.BYTE_WIDTH(BW), .DATA_WIDTH(DW)) bus ();
  cod5_fifo_write_packer #(.BYTE_WIDTH(BW), .BYTES_PER_WORD(BPW), .DATA_WIDTH(DW), .PAD_BYTE(PAD))
    dut (.write_clk_i(clk), .write_rst_ni(rst_n), .bus(bus));
  logic [BW-1:0] m_part[$];
  logic          m_hv, m_fl, m_done;
  logic [DW-1:0] m_hold;
  logic [15:0]   m_cnt;
  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic m_reset;
    m_part.delete();
    m_hv = 0; m_fl = 0; m_done = 0; m_hold = '0; m_cnt = '0;
  endtask
  task automatic step(input logic v, input logic [BW-1:0] d, input logic f, input logic full);
    logic er, ei, acc, cpl, nd, fl0;
    logic [DW-1:0] w;
    bus.in_valid_i = v; bus.in_data_i = d; bus.flush_i = f; bus.fifo_full_i = full;
    #2;
    er = !m_fl && (m_part.size() != BPW - 1 || !m_hv || !full);
    ei = m_hv && !full;
    chk("in_ready", 32'(bus.in_ready_o), 32'(er));
    chk("fifo_inc", 32'(bus.fifo_inc_o), 32'(ei));
    chk("fifo_data", 32'(bus.fifo_data_o), 32'(m_hold));
    chk("flush_done", 32'(bus.flush_done_o), 32'(m_done));
    chk("busy", 32'(bus.busy_o), 32'(m_hv || m_part.size() != 0 || m_fl));
    chk("word_count", 32'(bus.word_count_o), 32'(m_cnt));
    acc = v && er; cpl = 0; nd = 0; fl0 = m_fl; w = '0;
    if (acc) begin
      m_part.push_back(d);
      if (m_part.size() == BPW) begin
        for (int k = 0; k < BPW; k++) w[k*BW +: BW] = m_part[k];
        m_part.delete();
        cpl = 1;
      end
    end
    if (cpl) begin
      m_hold = w; m_hv = 1;
    end else if (fl0 && (!m_hv || ei)) begin
      for (int k = 0; k < BPW; k++) w[k*BW +: BW] = (k < m_part.size()) ? m_part[k] : PAD;
      m_part.delete();
      m_hold = w; m_hv = 1; m_fl = 0; nd = 1;
    end else if (ei) m_hv = 0;
    if (!fl0 && f) begin
      if (m_part.size() == 0) nd = 1;
      else m_fl = 1;
    end
    if (ei) m_cnt++;
    m_done = nd;
    @(posedge clk); #1;
  endtask
  task automatic idle(input logic full);
    bus.in_valid_i = 0; bus.in_data_i = '0; bus.flush_i = 0; bus.fifo_full_i = full;
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    m_reset();
    #2;
    chk("rst_ready", 32'(bus.in_ready_o), 32'd1);
    chk("rst_inc", 32'(bus.fifo_inc_o), 32'd0);
    chk("rst_data", 32'(bus.fifo_data_o), 32'd0);
    chk("rst_done", 32'(bus.flush_done_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_count", 32'(bus.word_count_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
  initial begin
    idle(1'b0);
    @(posedge clk); #1;
    do_reset();
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    idle(1'b0);
    chk("tp1_inc", 32'(bus.fifo_inc_o), 32'd1);
    chk("tp1_data", 32'(bus.fifo_data_o), 32'h2211);
    step(0, 8'h00, 0, 0);
    chk("tp1_count", 32'(bus.word_count_o), 32'd1);
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    step(0, 8'h00, 0, 0);
    chk("tp2_count", 32'(bus.word_count_o), 32'd9);
    step(1, 8'hAA, 0, 1);
    step(1, 8'hBB, 0, 1);
    step(1, 8'hCC, 0, 1);
    step(1, 8'hDD, 0, 1);
    idle(1'b1);
    chk("tp3_stall", 32'(bus.in_ready_o), 32'd0);
    chk("tp3_hold", 32'(bus.fifo_data_o), 32'hBBAA);
    step(1, 8'hDD, 0, 0);
    idle(1'b0);
    chk("tp3_second", 32'(bus.fifo_data_o), 32'hDDCC);
    step(0, 8'h00, 0, 0);
    step(1, 8'h5A, 0, 0);
    step(0, 8'h00, 1, 0);
    step(1, 8'h99, 0, 0);
    idle(1'b0);
    chk("tp4_done", 32'(bus.flush_done_o), 32'd1);
    chk("tp4_data", 32'(bus.fifo_data_o), 32'h005A);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);
    idle(1'b0);
    chk("tp5_done", 32'(bus.flush_done_o), 32'd1);
    chk("tp5_busy", 32'(bus.busy_o), 32'd0);
    step(0, 8'h00, 0, 0);
    step(1, 8'h34, 0, 1);
    step(1, 8'h12, 0, 1);
    step(1, 8'h77, 0, 1);
    idle(1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 3);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 0, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
